sram_arbiter_np: RTL

- N-master arbiter and controller for the asynchronous external SRAM, parametrised in port count, data width and wait states.
- Each master uses the existing bus style: address/rd/wr/byteenable/wrdata in, rddata/stall out.
- The SRAM side drives the shared pins; the top level maps them to base/ext chips.
- Round-robin arbitration; fixed, parametrised access timing.

---
 rtl/sram_arbiter_np.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter_np.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter_np
// Description : Round-robin arbiter and fixed-timing controller that shares
//               one asynchronous external SRAM between NUM_PORTS masters.
//               Each access runs SETUP -> ACCESS (WAIT_STATES+1) -> DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter_np #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 32,
    parameter int BE_W        = DATA_W / 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS*ADDR_W-1:0]         m_address,
    input  logic [NUM_PORTS*DATA_W-1:0]         m_wrdata,
    input  logic [NUM_PORTS*BE_W-1:0]           m_byteenable,
    input  logic [NUM_PORTS-1:0]                m_rd,
    input  logic [NUM_PORTS-1:0]                m_wr,
    output logic [NUM_PORTS*DATA_W-1:0]         m_rddata,
    output logic [NUM_PORTS-1:0]                m_stall,
    output logic [ADDR_W-$clog2(BE_W)-1:0]      ram_address,
    input  logic [DATA_W-1:0]                   ram_data_i,
    output logic [DATA_W-1:0]                   ram_data_o,
    output logic                                ram_io_t,
    output logic                                ram_ce_n,
    output logic                                ram_rd_n,
    output logic                                ram_wr_n,
    output logic [BE_W-1:0]                     dataenable_n
);

    localparam int c_PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_LSB = $clog2(BE_W);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_take;

    logic [NUM_PORTS-1:0]   w_req;
    logic [c_PW-1:0]        r_grant;
    logic [c_PW-1:0]        r_last_grant;
    logic [c_PW-1:0]        w_win_idx;
    logic                   w_win_valid;
    int                     w_best_dist;

    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_data;
    logic [BE_W-1:0]        w_sel_be;
    logic                   w_sel_wr;

    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wrdata;
    logic [BE_W-1:0]        r_be;
    logic                   r_is_wr;
    logic [3:0]             r_wait_cnt;
    logic [DATA_W-1:0]      r_rddata [NUM_PORTS];

    // Byte-in-word address bits are dropped on the SRAM side by design.
    logic                   w_unused_addr;
    assign w_unused_addr = ^{1'b0, r_addr};

    assign w_req = m_rd | m_wr;

    // Round-robin pick: smallest cyclic distance after last_grant wins; in DONE
    // the port just served is excluded so the others get their turn first.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        w_best_dist = NUM_PORTS;
        w_sel_addr  = '0;
        w_sel_data  = '0;
        w_sel_be    = '0;
        w_sel_wr    = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (w_req[k] && !(r_state == S_DONE && c_PW'(k) == r_grant)) begin
                if (((k + NUM_PORTS - 1 - int'(r_last_grant)) % NUM_PORTS) < w_best_dist) begin
                    w_best_dist = (k + NUM_PORTS - 1 - int'(r_last_grant)) % NUM_PORTS;
                    w_win_valid = 1'b1;
                    w_win_idx   = c_PW'(k);
                    w_sel_addr  = m_address[k*ADDR_W +: ADDR_W];
                    w_sel_data  = m_wrdata[k*DATA_W +: DATA_W];
                    w_sel_be    = m_byteenable[k*BE_W +: BE_W];
                    w_sel_wr    = m_wr[k];
                end
            end
        end
    end

    // Next-state logic; w_take marks the edge at which a new grant is latched.
    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_valid) begin
                    w_next_state = S_SETUP;
                    w_take       = 1'b1;
                end
            end
            S_SETUP:  w_next_state = S_ACCESS;
            S_ACCESS: begin
                if (r_wait_cnt == 4'd0) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (w_win_valid) begin
                    w_next_state = S_SETUP;
                    w_take       = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default:  w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grant bookkeeping, transaction latch and ACCESS down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= c_PW'(NUM_PORTS - 1);
            r_last_grant <= c_PW'(NUM_PORTS - 1);
            r_addr       <= '0;
            r_wrdata     <= '0;
            r_be         <= '0;
            r_is_wr      <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            if (w_take) begin
                r_grant      <= w_win_idx;
                r_last_grant <= w_win_idx;
                r_addr       <= w_sel_addr;
                r_wrdata     <= w_sel_data;
                r_be         <= w_sel_be;
                r_is_wr      <= w_sel_wr;
            end
            if (r_state == S_SETUP) begin
                r_wait_cnt <= 4'(WAIT_STATES);
            end else if (r_state == S_ACCESS && r_wait_cnt != 4'd0) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    // Read data is captured on the last ACCESS edge, even if the master left.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_rddata[p] <= '0;
            end
        end else if (r_state == S_ACCESS && r_wait_cnt == 4'd0 && !r_is_wr) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (c_PW'(p) == r_grant) begin
                    r_rddata[p] <= ram_data_i;
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
            assign m_rddata[i*DATA_W +: DATA_W] = r_rddata[i];
            assign m_stall[i] = w_req[i] & ~(r_state == S_DONE && r_grant == c_PW'(i));
        end
    endgenerate

    // SRAM strobes decoded from the registered state; DONE keeps CE low and
    // write data driven to meet the SRAM hold time after WE rises.
    assign ram_ce_n     = (r_state == S_IDLE);
    assign ram_rd_n     = ~(!r_is_wr && (r_state == S_SETUP || r_state == S_ACCESS));
    assign ram_wr_n     = ~(r_is_wr && r_state == S_ACCESS);
    assign ram_io_t     = ~(r_is_wr && r_state != S_IDLE);
    assign ram_address  = r_addr[ADDR_W-1:c_LSB];
    assign ram_data_o   = r_wrdata;
    assign dataenable_n = (r_state == S_IDLE) ? '1 : (r_is_wr ? ~r_be : '0);

endmodule
`default_nettype wire
